vlc_bit_packer: RTL and testbench

//   Downstream stage of the bit-serial VLC core. Collects data_out/dout_valid bits into W-bit words.

---
 rtl/vlc_bit_packer.sv | 156 +++++++++++++++
 tb/tb_vlc_bit_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlc_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : vlc_bit_packer
// Description : Packs the serial bit stream of the VLC core into W-bit words.
//               Bits are shifted in MSB-first. A word is pushed into a small
//               first-word-fall-through FIFO when W bits have been collected,
//               or when flush ends a stream with a partial word. Partial words
//               are left-aligned with zero padding, and word_nbits gives the
//               number of valid bits.
//               The VLC core cannot be stalled. A word that arrives while the
//               FIFO is full is dropped, and the sticky overflow flag is set.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               bit_in, bit_valid  - serial bit and its qualifier
//               flush              - pulse: emit the pending partial word
//               word_ready         - consumer accepts the head word
//               word_out           - head word, first received bit in MSB
//               word_nbits         - valid MSB bits in word_out (1..W)
//               word_valid         - FIFO non-empty
//               overflow           - sticky: a word was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module vlc_bit_packer #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    input  logic                   flush,
    input  logic                   word_ready,
    output logic [W-1:0]           word_out,
    output logic [$clog2(W+1)-1:0] word_nbits,
    output logic                   word_valid,
    output logic                   overflow
);

    localparam int c_CW = $clog2(W);       // bit counter, 0..W-1
    localparam int c_NW = $clog2(W+1);     // bit count including W
    localparam int c_AW = $clog2(DEPTH);   // FIFO pointer
    localparam int c_EW = c_NW + W;        // FIFO entry {nbits, word}

    // ------------------------------------------------------------------
    // Bit collector
    // ------------------------------------------------------------------
    logic [W-1:0]      r_sr;
    logic [c_CW-1:0]   r_cnt;

    logic [W-1:0]      w_sr_next;
    logic [c_NW-1:0]   w_n;
    logic              w_word_done;
    logic              w_push;
    logic [W-1:0]      w_aligned;
    logic [c_EW-1:0]   w_entry;

    // The shift register value after this edge. Its low w_n bits are the
    // pending bits, including this cycle's bit.
    assign w_sr_next   = bit_valid ? {r_sr[W-2:0], bit_in} : r_sr;
    assign w_n         = c_NW'(r_cnt) + c_NW'(bit_valid);
    assign w_word_done = bit_valid && (r_cnt == c_CW'(W-1));
    // A flush that coincides with the W-th bit is covered by the full-word
    // push, so it produces only one word.
    assign w_push      = w_word_done || (flush && (w_n != '0));
    // Left-align the pending bits. This discards stale bits above them and
    // zero-pads the LSBs. A full word shifts by zero.
    assign w_aligned   = w_sr_next << (c_NW'(W) - w_n);
    assign w_entry     = {w_n, w_aligned};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            r_sr <= w_sr_next;
            if (w_push) begin
                r_cnt <= '0;
            end else if (bit_valid) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO with registered head outputs
    // ------------------------------------------------------------------
    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [W-1:0]      r_word;
    logic [c_NW-1:0]   r_nbits;
    logic              r_valid;
    logic              r_overflow;

    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;
    logic [c_AW-1:0]   w_rd_next;
    logic [c_AW:0]     w_count_next;
    logic [c_EW-1:0]   w_head;

    assign w_full       = (r_count == (c_AW+1)'(DEPTH));
    assign w_pop        = r_valid && word_ready;
    // A full FIFO that pops this cycle has room for the push.
    assign w_accept     = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_rd_next    = r_rd_ptr + c_AW'(w_pop);
    assign w_count_next = r_count + (c_AW+1)'(w_accept) - (c_AW+1)'(w_pop);
    // When the next head is the slot being written on this edge, bypass the
    // memory. This gives fall-through when the FIFO is empty or drains to
    // empty.
    assign w_head       = (w_accept && (w_rd_next == r_wr_ptr)) ? w_entry
                                                                 : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_nbits    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            // The head only changes on a pop or on the first push. Otherwise
            // w_head equals the current head, so the output stays stable.
            if (w_count_next != '0) begin
                r_word  <= w_head[W-1:0];
                r_nbits <= w_head[c_EW-1:W];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign word_out   = r_word;
    assign word_nbits = r_nbits;
    assign word_valid = r_valid;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vlc_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vlc_bit_packer
// Description : Self-checking bench for vlc_bit_packer (W=8, DEPTH=4).
//               Directed vectors and sequences are compared against constants.
//               Every cycle is also compared against a queue-based
//               reference model, which is then driven with random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vlc_bit_packer;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       flush = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_out;
    logic [3:0] word_nbits;
    logic       word_valid;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    vlc_bit_packer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .flush      (flush),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_nbits (word_nbits),
        .word_valid (word_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: pending bits, a queue of words, and a sticky flag
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] w;
        logic [3:0] n;
    } word_t;

    bit    m_pend[$];
    word_t m_q[$];
    bit    m_ovf;

    task automatic model_clear();
        m_pend.delete();
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic bv, input logic b, input logic fl, input logic rdy);
        word_t nw;
        bit    pop;
        pop = (m_q.size() > 0) && rdy;
        if (bv) m_pend.push_back(b);
        if (pop) void'(m_q.pop_front());
        if (m_pend.size() == W || (fl && m_pend.size() > 0)) begin
            nw.w = '0;
            for (int i = 0; i < m_pend.size(); i++) nw.w[W-1-i] = m_pend[i];
            nw.n = 4'(m_pend.size());
            m_pend.delete();
            if (m_q.size() < DEPTH) m_q.push_back(nw);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("model_valid", 32'(word_valid), 32'(m_q.size() != 0));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk("model_word", 32'(word_out), 32'(m_q[0].w));
            chk("model_nbits", 32'(word_nbits), 32'(m_q[0].n));
        end
    endtask

    // One clock: inputs applied at the negedge, outputs checked at the next negedge.
    task automatic cycle(input logic bv, input logic b, input logic fl, input logic rdy);
        bit_valid  = bv;
        bit_in     = b;
        flush      = fl;
        word_ready = rdy;
        @(posedge clk);
        model_step(bv, b, fl, rdy);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bit_valid  = 1'b1;
        bit_in     = 1'b1;
        flush      = 1'b0;
        word_ready = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst       = 1'b0;
        bit_valid = 1'b0;
        model_check();
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [7:0] w,
                              input logic [3:0] n, input logic o);
        chk({nm, "_valid"}, 32'(word_valid), 32'(v));
        chk({nm, "_ovf"}, 32'(overflow), 32'(o));
        if (v) begin
            chk({nm, "_word"}, 32'(word_out), 32'(w));
            chk({nm, "_nbits"}, 32'(word_nbits), 32'(n));
        end
    endtask

    // Sends 8 bits MSB-first, with word_ready held at rdy_first for the
    // first 7 bits and rdy_last on the 8th.
    task automatic send_byte(input logic [7:0] v, input logic rdy_first, input logic rdy_last);
        for (int i = 7; i >= 0; i--) cycle(1'b1, v[i], 1'b0, (i == 0) ? rdy_last : rdy_first);
    endtask

    // Checks each expected head word and then pops it.
    task automatic drain(input logic [7:0] exp_words[$], input logic o);
        for (int i = 0; i < exp_words.size(); i++) begin
            expect_out($sformatf("drain%0d", i), 1'b1, exp_words[i], 4'd8, o);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        expect_out("drain_empty", 1'b0, 8'h00, 4'd0, o);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: one record per clock
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic       bv, b, fl, rdy;
        logic       ev;
        logic [7:0] ew;
        logic [3:0] en;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic bv, input logic b, input logic fl,
                       input logic rdy, input logic ev, input logic [7:0] ew,
                       input logic [3:0] en);
        vec_t v;
        v.name = nm; v.bv = bv; v.b = b; v.fl = fl; v.rdy = rdy;
        v.ev = ev; v.ew = ew; v.en = en; v.eo = 1'b0;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_q[$];
        int         duty;

        @(negedge clk);
        do_reset();
        expect_out("reset", 1'b0, 8'h00, 4'd0, 1'b0);
        chk("reset_word", 32'(word_out), 32'h0);
        chk("reset_nbits", 32'(word_nbits), 32'h0);

        // Test 1: 1,0,1,1,0,0,1,0 -> B2/8. Then a pop empties the FIFO.
        pat = 8'hB2;
        for (int i = 7; i >= 1; i--) add("t1_bit", 1'b1, pat[i], 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
        add("t1_word", 1'b1, pat[0], 1'b0, 1'b1, 1'b1, 8'hB2, 4'd8);
        add("t1_pop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
        // Test 2: 1,1,0 then flush -> C0/3, held while not ready, one word only.
        add("t2_bit", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
        add("t2_bit", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
        add("t2_bit", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
        add("t2_flush", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC0, 4'd3);
        add("t2_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC0, 4'd3);
        add("t2_pop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
        add("t2_one", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);

        foreach (tbl[i]) begin
            cycle(tbl[i].bv, tbl[i].b, tbl[i].fl, tbl[i].rdy);
            expect_out(tbl[i].name, tbl[i].ev, tbl[i].ew, tbl[i].en, tbl[i].eo);
        end

        // Test 3: flush on the 8th bit gives a single full word.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        expect_out("t3_word", 1'b1, 8'hFF, 4'd8, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("t3_single", 1'b0, 8'h00, 4'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("t3_flush_empty", 1'b0, 8'h00, 4'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("t3_after", 1'b0, 8'h00, 4'd0, 1'b0);

        // Test 5: with the FIFO full, a pop on the completing edge lets the
        // push through.
        for (int k = 1; k <= 4; k++) send_byte(8'(k * 8'h11), 1'b0, 1'b0);
        expect_out("t5_full", 1'b1, 8'h11, 4'd8, 1'b0);
        send_byte(8'h55, 1'b0, 1'b1);
        expect_out("t5_swap", 1'b1, 8'h22, 4'd8, 1'b0);
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        drain(exp_q, 1'b0);

        // Test 4: a fifth word with no pop is dropped, and overflow stays set.
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0, 1'b0);
        expect_out("t4_four", 1'b1, 8'h01, 4'd8, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        expect_out("t4_ovf", 1'b1, 8'h01, 4'd8, 1'b1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        drain(exp_q, 1'b1);

        // Test 6: reset mid-word discards the partial bits and clears overflow.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        expect_out("t6_reset", 1'b0, 8'h00, 4'd0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        expect_out("t6_word", 1'b1, 8'h5A, 4'd8, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model. The ready duty changes per
        // segment so that both overflow and steady draining are exercised.
        for (int seg = 0; seg < 12; seg++) begin
            duty = (seg % 4 == 0) ? 5 : int'($urandom_range(10, 100));
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 15) == 0),
                          1'(int'($urandom_range(0, 99)) < duty));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
